udp_tx_arbiter: RTL and testbench

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

---
 rtl/udp_tx_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_udp_tx_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: two-requester round-robin arbiter that feeds UDP payload
// frames into a UDP transmit core.
//
// Ports
//   e_rxc, rst           : clock and synchronous active-high reset
//   req0/1, len0/1       : frame request (level) and payload length in bytes
//   data0/1, rd0/1       : first-word-fall-through payload source and its pop strobe
//   done0/1, err0/1      : one-cycle completion / rejection-or-timeout pulses
//   tx_start             : one-cycle frame start to the UDP core
//   tx_data_req, tx_data : word request from the core and the muxed payload word
//   tx_data_length       : UDP length (payload + 8)
//   tx_total_length      : IP total length (payload + 28)
//   busy, grant          : FSM not idle, index of the current/most recent owner
module udp_tx_arbiter #(
    parameter int unsigned GAP_CYCLES  = 64,
    parameter int unsigned MAX_PAYLOAD = 1472,
    parameter int unsigned TIMEOUT     = 4096
) (
    input  logic        e_rxc,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] len0,
    input  logic [15:0] len1,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    output logic        rd0,
    output logic        rd1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        tx_start,
    input  logic        tx_data_req,
    output logic [31:0] tx_data,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    output logic        busy,
    output logic        grant
);

    localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StStart, StSend, StGap} state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_q, last_d;
    logic [13:0]       words_q, words_d;
    logic [13:0]       cnt_q, cnt_d;
    logic [15:0]       dlen_q, dlen_d;
    logic [15:0]       tlen_q, tlen_d;
    logic              start_q, start_d;
    logic              done0_q, done0_d, done1_q, done1_d;
    logic              err0_q, err0_d, err1_q, err1_d;
    // A rejected requester stays blocked until it drops req for a cycle.
    logic              blk0_q, blk0_d, blk1_q, blk1_d;
    logic [ToW-1:0]    to_q, to_d;
    logic [GapW-1:0]   gap_q, gap_d;

    logic        act0, act1, elig0, elig1, pick;
    logic [15:0] sel_len;

    always_comb begin
        act0  = req0 && !blk0_q;
        act1  = req1 && !blk1_q;
        elig0 = act0 && (len0 != 16'd0) && (len0[1:0] == 2'b00) && (len0 <= 16'(MAX_PAYLOAD));
        elig1 = act1 && (len1 != 16'd0) && (len1[1:0] == 2'b00) && (len1 <= 16'(MAX_PAYLOAD));
        // Round-robin on contention: the requester that did not own last.
        pick    = (elig0 && elig1) ? !last_q : elig1;
        sel_len = pick ? len1 : len0;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        words_d = words_q;
        cnt_d   = cnt_q;
        dlen_d  = dlen_q;
        tlen_d  = tlen_q;
        start_d = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        err0_d  = 1'b0;
        err1_d  = 1'b0;
        blk0_d  = blk0_q && req0;
        blk1_d  = blk1_q && req1;
        to_d    = to_q;
        gap_d   = gap_q;

        unique case (state_q)
            StIdle: begin
                if (act0 && !elig0) begin
                    err0_d = 1'b1;
                    blk0_d = 1'b1;
                end
                if (act1 && !elig1) begin
                    err1_d = 1'b1;
                    blk1_d = 1'b1;
                end
                if (elig0 || elig1) begin
                    grant_d = pick;
                    last_d  = pick;
                    words_d = sel_len[15:2];
                    dlen_d  = sel_len + 16'd8;
                    tlen_d  = sel_len + 16'd28;
                    start_d = 1'b1;
                    cnt_d   = '0;
                    to_d    = '0;
                    state_d = StStart;
                end
            end
            StStart: state_d = StSend;
            StSend: begin
                if (tx_data_req) begin
                    to_d = '0;
                    if (cnt_q + 14'd1 == words_q) begin
                        cnt_d   = '0;
                        done0_d = !grant_q;
                        done1_d = grant_q;
                        gap_d   = '0;
                        state_d = StGap;
                    end else begin
                        cnt_d = cnt_q + 14'd1;
                    end
                end else if (to_q == ToW'(TIMEOUT - 1)) begin
                    // Core stalled: drop the frame without a done.
                    err0_d  = !grant_q;
                    err1_d  = grant_q;
                    cnt_d   = '0;
                    to_d    = '0;
                    gap_d   = '0;
                    state_d = StGap;
                end else begin
                    to_d = to_q + ToW'(1);
                end
            end
            StGap: begin
                if (gap_q == GapW'(GAP_CYCLES - 1)) begin
                    gap_d   = '0;
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge e_rxc) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            words_q <= '0;
            cnt_q   <= '0;
            dlen_q  <= '0;
            tlen_q  <= '0;
            start_q <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            blk0_q  <= 1'b0;
            blk1_q  <= 1'b0;
            to_q    <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            words_q <= words_d;
            cnt_q   <= cnt_d;
            dlen_q  <= dlen_d;
            tlen_q  <= tlen_d;
            start_q <= start_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
            blk0_q  <= blk0_d;
            blk1_q  <= blk1_d;
            to_q    <= to_d;
            gap_q   <= gap_d;
        end
    end

    assign rd0             = tx_data_req && (state_q == StSend) && !grant_q;
    assign rd1             = tx_data_req && (state_q == StSend) && grant_q;
    assign tx_data         = (state_q == StSend) ? (grant_q ? data1 : data0) : 32'd0;
    assign tx_start        = start_q;
    assign done0           = done0_q;
    assign done1           = done1_q;
    assign err0            = err0_q;
    assign err1            = err1_q;
    assign tx_data_length  = dlen_q;
    assign tx_total_length = tlen_q;
    assign busy            = (state_q != StIdle);
    assign grant           = grant_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: stimulus pushes expected events,
// a negedge monitor pops and compares every event the DUT presents.
module tb_udp_tx_arbiter;

    localparam int unsigned G   = 16;
    localparam int unsigned MAX = 1472;
    localparam int unsigned T   = 64;

    localparam logic [2:0] KStart = 3'd1;
    localparam logic [2:0] KRd    = 3'd2;
    localparam logic [2:0] KDone  = 3'd3;
    localparam logic [2:0] KErr   = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic        idx;
        logic [31:0] data;
        logic [15:0] dlen;
        logic [15:0] tlen;
    } ev_t;

    logic        e_rxc = 1'b0;
    logic        rst, req0, req1, tx_data_req;
    logic [15:0] len0, len1;
    logic [31:0] data0, data1;
    logic        rd0, rd1, done0, done1, err0, err1, tx_start, busy, grant;
    logic [31:0] tx_data;
    logic [15:0] tx_data_length, tx_total_length;

    int   n_checks = 0;
    int   n_fail   = 0;
    ev_t  exp_q[$];
    int   exp_ptr[2];
    int   ptr0 = 0;
    int   ptr1 = 0;
    int   since_done = 1000;

    udp_tx_arbiter #(
        .GAP_CYCLES (G),
        .MAX_PAYLOAD(MAX),
        .TIMEOUT    (T)
    ) dut (
        .e_rxc          (e_rxc),
        .rst            (rst),
        .req0           (req0),
        .req1           (req1),
        .len0           (len0),
        .len1           (len1),
        .data0          (data0),
        .data1          (data1),
        .rd0            (rd0),
        .rd1            (rd1),
        .done0          (done0),
        .done1          (done1),
        .err0           (err0),
        .err1           (err1),
        .tx_start       (tx_start),
        .tx_data_req    (tx_data_req),
        .tx_data        (tx_data),
        .tx_data_length (tx_data_length),
        .tx_total_length(tx_total_length),
        .busy           (busy),
        .grant          (grant)
    );

    always #4 e_rxc = ~e_rxc;

    // First-word-fall-through word sources.
    assign data0 = 32'hA000_0000 + 32'(ptr0);
    assign data1 = 32'hB000_0000 + 32'(ptr1);
    always @(posedge e_rxc) begin
        if (rd0) ptr0 <= ptr0 + 1;
        if (rd1) ptr1 <= ptr1 + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge e_rxc);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [2:0] k, input logic i, input logic [31:0] d,
                        input logic [15:0] dl, input logic [15:0] tl);
        ev_t e;
        e.kind = k; e.idx = i; e.data = d; e.dlen = dl; e.tlen = tl;
        exp_q.push_back(e);
    endtask

    task automatic observe(input logic [2:0] k, input logic i, input logic [31:0] d,
                           input logic [15:0] dl, input logic [15:0] tl);
        ev_t got, exp;
        got.kind = k; got.idx = i; got.data = d; got.dlen = dl; got.tlen = tl;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got kind=%0d idx=%0d data=%h dlen=%0d tlen=%0d, required none",
                     k, i, d, dl, tl);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                n_fail++;
                $display("FAIL sb_event: got kind=%0d idx=%0d data=%h dlen=%0d tlen=%0d, required kind=%0d idx=%0d data=%h dlen=%0d tlen=%0d",
                         k, i, d, dl, tl, exp.kind, exp.idx, exp.data, exp.dlen, exp.tlen);
            end
        end
    endtask

    // Monitor: one pass per cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge e_rxc);
            if (rst) begin
                since_done = 1000;
            end else begin
                if (done0 || done1) since_done = 0;
                else if (since_done < 1000) since_done++;
                if (err0)  observe(KErr, 1'b0, 32'd0, 16'd0, 16'd0);
                if (err1)  observe(KErr, 1'b1, 32'd0, 16'd0, 16'd0);
                if (done0) observe(KDone, 1'b0, 32'd0, 16'd0, 16'd0);
                if (done1) observe(KDone, 1'b1, 32'd0, 16'd0, 16'd0);
                if (tx_start) begin
                    observe(KStart, grant, 32'd0, tx_data_length, tx_total_length);
                    check("start_after_gap", 32'(since_done > int'(G)), 32'd1);
                end
                if (rd0) observe(KRd, 1'b0, tx_data, 16'd0, 16'd0);
                if (rd1) observe(KRd, 1'b1, tx_data, 16'd0, 16'd0);
            end
        end
    end

    function automatic logic flag(input int sel);
        case (sel)
            0:       return tx_start;
            1:       return err0;
            default: return done0;
        endcase
    endfunction

    task automatic wait_evt(input int sel, input int budget, output int waited);
        waited = 0;
        while (!flag(sel) && waited < budget) begin
            tick(1);
            waited++;
        end
        if (!flag(sel)) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_evt%0d: got no event in %0d cycles, required event", sel, budget);
        end
    endtask

    // Issue n word requests; with_done ends in the cycle done is expected.
    task automatic pulse_words(input logic idx, input int n, input bit with_done);
        for (int i = 0; i < n; i++) begin
            push(KRd, idx, (idx ? 32'hB000_0000 : 32'hA000_0000) + 32'(exp_ptr[idx]),
                 16'd0, 16'd0);
            exp_ptr[idx]++;
            if (with_done && i == n - 1) push(KDone, idx, 32'd0, 16'd0, 16'd0);
            tx_data_req = 1'b1;
            tick(1);
            tx_data_req = 1'b0;
            if (i != n - 1) tick(1);
        end
    endtask

    // Called in the first GAP cycle with no pending requests.
    task automatic gap_busy_check();
        check("gap_busy_first", 32'(busy), 32'd1);
        tick(G - 1);
        check("gap_busy_last", 32'(busy), 32'd1);
        tick(1);
        check("gap_idle_after", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int w;
        logic [15:0] bad [3];
        bad[0] = 16'd6; bad[1] = 16'd0; bad[2] = 16'd1476;
        exp_ptr[0] = 0; exp_ptr[1] = 0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0; tx_data_req = 1'b0;
        tick(3);

        // Reset values
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_dlen", 32'(tx_data_length), 32'd0);
        check("rst_tlen", 32'(tx_total_length), 32'd0);
        check("rst_flags", {28'd0, done0, done1, err0, err1}, 32'd0);
        rst = 1'b0;
        tick(1);

        // Stray request in IDLE
        tx_data_req = 1'b1;
        check("idle_stray_rd", {30'd0, rd0, rd1}, 32'd0);
        check("idle_stray_data", tx_data, 32'd0);
        tx_data_req = 1'b0;
        tick(1);

        // Single frame, len 16
        push(KStart, 1'b0, 32'd0, 16'd24, 16'd44);
        req0 = 1'b1; len0 = 16'd16;
        wait_evt(0, 10, w);
        check("first_grant_latency", 32'(w), 32'd1);
        tick(1);
        pulse_words(1'b0, 4, 1'b1);
        req0 = 1'b0; len0 = '0;
        check("single_gap_busy", 32'(busy), 32'd1);
        tick(2);
        tx_data_req = 1'b1;
        check("gap_stray_rd", {30'd0, rd0, rd1}, 32'd0);
        check("gap_stray_data", tx_data, 32'd0);
        tx_data_req = 1'b0;
        tick(G - 3);
        check("single_gap_end_busy", 32'(busy), 32'd1);
        tick(1);
        check("single_idle", 32'(busy), 32'd0);
        check("dlen_hold", 32'(tx_data_length), 32'd24);
        check("tlen_hold", 32'(tx_total_length), 32'd44);

        // Contention: 0, then 1, then 0
        do_reset();
        push(KStart, 1'b0, 32'd0, 16'd16, 16'd36);
        req0 = 1'b1; len0 = 16'd8; req1 = 1'b1; len1 = 16'd8;
        wait_evt(0, 10, w);
        tick(1);
        pulse_words(1'b0, 2, 1'b1);
        push(KStart, 1'b1, 32'd0, 16'd16, 16'd36);
        req0 = 1'b0;
        tick(1);
        req0 = 1'b1;
        wait_evt(0, G + 10, w);
        tick(1);
        pulse_words(1'b1, 2, 1'b1);
        push(KStart, 1'b0, 32'd0, 16'd16, 16'd36);
        req1 = 1'b0;
        wait_evt(0, G + 10, w);
        tick(1);
        pulse_words(1'b0, 2, 1'b1);
        req0 = 1'b0;
        gap_busy_check();

        // Rejections on requester 1 alongside a valid requester 0
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push(KErr, 1'b1, 32'd0, 16'd0, 16'd0);
            push(KStart, 1'b0, 32'd0, 16'd16, 16'd36);
            req0 = 1'b1; len0 = 16'd8; req1 = 1'b1; len1 = bad[k];
            wait_evt(0, 10, w);
            tick(1);
            pulse_words(1'b0, 2, 1'b1);
            req0 = 1'b0;
            tick(G + 2);
            req1 = 1'b0;
            tick(2);
        end

        // Timeout after one word
        do_reset();
        push(KStart, 1'b0, 32'd0, 16'd16, 16'd36);
        req0 = 1'b1; len0 = 16'd8;
        wait_evt(0, 10, w);
        tick(1);
        pulse_words(1'b0, 1, 1'b0);
        push(KErr, 1'b0, 32'd0, 16'd0, 16'd0);
        wait_evt(1, T + 10, w);
        check("timeout_cycles", 32'(w), 32'(T));
        req0 = 1'b0;
        gap_busy_check();

        // Reset in the middle of SEND
        push(KStart, 1'b0, 32'd0, 16'd24, 16'd44);
        req0 = 1'b1; len0 = 16'd16;
        wait_evt(0, 10, w);
        tick(1);
        pulse_words(1'b0, 2, 1'b0);
        rst = 1'b1; req0 = 1'b0;
        tick(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_outs", {25'd0, rd0, rd1, done0, done1, err0, err1, tx_start}, 32'd0);
        check("midrst_lens", {tx_data_length, tx_total_length}, 32'd0);
        check("midrst_data", tx_data, 32'd0);
        rst = 1'b0;
        push(KStart, 1'b1, 32'd0, 16'd16, 16'd36);
        req1 = 1'b1; len1 = 16'd8;
        tick(1);
        check("post_rst_start", 32'(tx_start), 32'd1);
        tick(1);
        pulse_words(1'b1, 2, 1'b1);
        req1 = 1'b0;
        gap_busy_check();

        tick(5);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

endmodule
